hash_arbiter: RTL and testbench

HASH_ARBITER -- requirements
Module: hash_arbiter

---
 rtl/hash_arbiter.sv | 92 +++++++++
 tb/tb_hash_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hash_arbiter.sv
// hash_arbiter: round-robin arbiter feeding two byte-stream requesters into one hash core,
// with zero-length rejection and a hash_ready timeout.
module hash_arbiter #(
  parameter int LEN_W   = 64,
  parameter int DIG_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  input  logic [7:0]       byte0,
  input  logic [7:0]       byte1,
  input  logic [1:0]       byte_valid,
  output logic [1:0]       byte_ready,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic [DIG_W-1:0] digest_out,
  output logic [7:0]       core_M,
  output logic             core_M_valid,
  output logic [LEN_W-1:0] core_len,
  input  logic             core_hash_ready,
  input  logic [DIG_W-1:0] core_digest
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, WAIT, FINISH} state_t;
  state_t           state;
  logic             g, last, acc, ng;
  logic [1:0]       oh, done_r, err_r;
  logic [7:0]       m_last, bsel;
  logic [LEN_W-1:0] cnt, nlen;
  logic [TW-1:0]    tcnt;
  always_comb begin
    oh   = g ? 2'b10 : 2'b01;
    bsel = g ? byte1 : byte0;
    acc  = (state == STREAM) && byte_valid[g];
    ng   = (&req) ? ~last : req[1];
    nlen = ng ? req_len1 : req_len0;
  end
  assign byte_ready   = (state == STREAM) ? oh : 2'b00;
  assign core_M_valid = acc;
  assign core_M       = acc ? bsel : m_last;
  assign done         = done_r;
  assign err          = err_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      g          <= 1'b0;
      last       <= 1'b1;
      cnt        <= '0;
      tcnt       <= '0;
      m_last     <= '0;
      core_len   <= '0;
      digest_out <= '0;
      done_r     <= '0;
      err_r      <= '0;
    end else begin
      done_r <= '0;
      err_r  <= '0;
      if (acc) m_last <= bsel;
      case (state)
        IDLE: if (|req) begin
          g        <= ng;
          last     <= ng;
          core_len <= nlen;
          cnt      <= nlen;
          state    <= LOAD;
          if (nlen == '0) err_r <= ng ? 2'b10 : 2'b01;
        end
        LOAD: state <= (cnt == '0) ? IDLE : STREAM;
        STREAM: if (acc) begin
          cnt <= cnt - 1'b1;
          if (cnt == LEN_W'(1)) begin
            state <= WAIT;
            tcnt  <= '0;
          end
        end
        WAIT: if (core_hash_ready) begin
          digest_out <= core_digest;
          done_r     <= oh;
          state      <= FINISH;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_r <= oh;
          state <= IDLE;
        end else tcnt <= tcnt + 1'b1;
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter: scoreboard bench; bytes expected on core_M are queued as they are offered
// and popped by a negedge monitor.
module tb_hash_arbiter;
  localparam int LEN_W = 64, DIG_W = 32, TIMEOUT = 16;
  logic clk = 0, rst = 1;
  logic [1:0] req = 0, byte_valid = 0;
  logic [LEN_W-1:0] req_len0 = 0, req_len1 = 0;
  logic [7:0] byte0 = 0, byte1 = 0;
  logic core_hash_ready = 0;
  logic [DIG_W-1:0] core_digest = 0;
  logic [1:0] byte_ready, done, err;
  logic [DIG_W-1:0] digest_out;
  logic [7:0] core_M;
  logic core_M_valid;
  logic [LEN_W-1:0] core_len;
  int ntot = 0, npass = 0, nacc = 0;
  logic [7:0] q[$];
  string msg = "Welcome_to_testing";

  hash_arbiter #(.LEN_W(LEN_W), .DIG_W(DIG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len0(req_len0), .req_len1(req_len1),
    .byte0(byte0), .byte1(byte1), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .done(done), .err(err), .digest_out(digest_out), .core_M(core_M),
    .core_M_valid(core_M_valid), .core_len(core_len),
    .core_hash_ready(core_hash_ready), .core_digest(core_digest)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst) begin
    logic [7:0] e;
    ntot++;
    if ($onehot0(done) && $onehot0(err) && $onehot0(byte_ready)) npass++;
    else $display("FAIL onehot: done=%b err=%b byte_ready=%b", done, err, byte_ready);
    if (core_M_valid) begin
      nacc++;
      ntot++;
      if (q.size() == 0) $display("FAIL core_M: got %h, required no byte", core_M);
      else begin
        e = q.pop_front();
        if (core_M === e) npass++;
        else $display("FAIL core_M: got %h, required %h", core_M, e);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int r, input int len, input bit gap, input bit tmo,
                         input int abort, input logic [DIG_W-1:0] d);
    logic [1:0] oh;
    logic [DIG_W-1:0] dig0;
    int cyc, i, acc0;
    bit v, ok;
    oh = r ? 2'b10 : 2'b01;
    cyc = 0;
    while (byte_ready == 0 && cyc < 10) begin step; cyc++; end
    ntot++;
    if (byte_ready === oh && core_len === LEN_W'(len)) npass++;
    else $display("FAIL grant: byte_ready=%b core_len=%0d, required %b %0d", byte_ready, core_len, oh, len);
    acc0 = nacc;
    i = 0;
    cyc = 0;
    while (i < len && cyc < 200) begin
      if (i == abort) begin
        rst = 1;
        #1;
        ntot++;
        if ({byte_ready, done, err, core_M_valid, core_M} === '0 && core_len === '0 && digest_out === '0) npass++;
        else $display("FAIL async_reset: byte_ready=%b done=%b err=%b valid=%b M=%h len=%0d dig=%h, required all 0",
                      byte_ready, done, err, core_M_valid, core_M, core_len, digest_out);
        q.delete();
        byte_valid = 0;
        req = 0;
        step;
        ntot++;
        if (done === 0 && err === 0) npass++;
        else $display("FAIL reset_pulse: done=%b err=%b, required 00 00", done, err);
        rst = 0;
        step;
        return;
      end
      v = !gap || (cyc % 2 == 0);
      byte_valid[r] = v;
      byte_valid[1-r] = 1'b1;
      if (r != 0) begin byte1 = msg[i]; byte0 = 8'hEE; end
      else begin byte0 = msg[i]; byte1 = 8'hEE; end
      if (v && byte_ready[r]) begin q.push_back(msg[i]); i++; end
      cyc++;
      step;
    end
    byte_valid = 0;
    ntot++;
    if (nacc - acc0 == len && byte_ready === 0 && q.size() == 0) npass++;
    else $display("FAIL accepts: got %0d byte_ready=%b pending=%0d, required %0d 00 0", nacc - acc0, byte_ready, q.size(), len);
    dig0 = digest_out;
    if (!tmo) begin
      core_digest = d;
      core_hash_ready = 1;
      step;
      core_hash_ready = 0;
      ntot++;
      if (done === oh && err === 0 && digest_out === d) npass++;
      else $display("FAIL done: done=%b err=%b digest=%h, required %b 00 %h", done, err, digest_out, oh, d);
      req[r] = 0;
      step;
      ntot++;
      if (done === 0 && digest_out === d) npass++;
      else $display("FAIL done_pulse: done=%b digest=%h, required 00 %h", done, digest_out, d);
    end else begin
      req[r] = 0;
      ok = 1;
      for (int k = 1; k < TIMEOUT; k++) begin
        step;
        if (err !== 0 || done !== 0) ok = 0;
      end
      ntot++;
      if (ok) npass++;
      else $display("FAIL early_timeout: err or done before %0d cycles, required none", TIMEOUT);
      step;
      ntot++;
      if (err === oh && done === 0 && digest_out === dig0) npass++;
      else $display("FAIL timeout: err=%b done=%b digest=%h, required %b 00 %h", err, done, digest_out, oh, dig0);
      step;
      ntot++;
      if (err === 0 && byte_ready === 0) npass++;
      else $display("FAIL timeout_idle: err=%b byte_ready=%b, required 00 00", err, byte_ready);
    end
  endtask

  task automatic test_reset;
    byte_valid = 2'b11;
    step;
    step;
    ntot++;
    if ({byte_ready, done, err, core_M_valid, core_M} === '0 && core_len === '0 && digest_out === '0) npass++;
    else $display("FAIL reset: byte_ready=%b done=%b err=%b valid=%b M=%h, required all 0",
                  byte_ready, done, err, core_M_valid, core_M);
    byte_valid = 0;
    rst = 0;
    step;
    ntot++;
    if (byte_ready === 0 && core_M_valid === 0) npass++;
    else $display("FAIL idle: byte_ready=%b valid=%b, required 00 0", byte_ready, core_M_valid);
  endtask

  task automatic test_tie;
    for (int t = 0; t < 2; t++) begin
      req_len0 = 18;
      req_len1 = 5;
      req = 2'b11;
      run_txn(0, 18, 0, 0, -1, 32'hA000_0000 + t);
      run_txn(1, 5, 0, 0, -1, 32'hB000_0000 + t);
    end
  endtask

  task automatic test_single;
    req_len0 = 18;
    req = 2'b01;
    run_txn(0, 18, 0, 0, -1, 32'h1234_ABCD);
  endtask

  task automatic test_gapped;
    req_len0 = 18;
    req = 2'b01;
    run_txn(0, 18, 1, 0, -1, 32'h1234_ABCD);
  endtask

  task automatic test_zero_len;
    int a0;
    a0 = nacc;
    req_len1 = 0;
    req = 2'b10;
    step;
    ntot++;
    if (err === 2'b10 && done === 0 && core_len === 0) npass++;
    else $display("FAIL zero_len: err=%b done=%b len=%0d, required 10 00 0", err, done, core_len);
    req = 0;
    step;
    ntot++;
    if (err === 0 && nacc == a0 && byte_ready === 0) npass++;
    else $display("FAIL zero_len_after: err=%b accepts=%0d, required 00 0", err, nacc - a0);
  endtask

  task automatic test_timeout;
    req_len0 = 4;
    req = 2'b01;
    run_txn(0, 4, 0, 1, -1, '0);
  endtask

  task automatic test_reset_mid;
    req_len0 = 18;
    req = 2'b01;
    run_txn(0, 18, 0, 0, 7, '0);
    req_len0 = 18;
    req = 2'b11;
    req_len1 = 3;
    run_txn(0, 18, 0, 0, -1, 32'h5555_AAAA);
    run_txn(1, 3, 0, 0, -1, 32'h0BAD_F00D);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_tie;
    test_single;
    test_gapped;
    test_zero_len;
    test_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
